cve2_instr_obi_responder: RTL and testbench



---
 rtl/cve2_pkg.sv | 18 +
 rtl/cve2_imem_addr_check.sv | 25 ++
 rtl/cve2_instr_obi_responder.sv | 108 ++++++++++
 tb/tb_cve2_instr_obi_responder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cve2_pkg.sv
// Shared types for the cve2 instruction-memory responder.
package cve2_pkg;

  localparam int unsigned ImemCntW = 4;

  typedef enum logic [0:0] {
    IMEM_IDLE = 1'b0,
    IMEM_WAIT = 1'b1
  } imem_resp_state_e;

  // Initial wait-counter value for a request entering the wait state.
  function automatic logic [ImemCntW-1:0] imem_wait_init(input int unsigned wait_cycles);
    logic [31:0] w;
    w = wait_cycles - 32'd1;
    return w[ImemCntW-1:0];
  endfunction

endpackage

// File: rtl/cve2_imem_addr_check.sv
// Combinational window/alignment check for instruction fetch addresses.
module cve2_imem_addr_check #(
  parameter logic [31:0] MemBase      = 32'h0000_0000,
  parameter int unsigned MemSizeBytes = 32768
) (
  input  logic [31:0] addr_i,
  input  logic        addr_err_o_unused_dummy,
  output logic        addr_err_o
);

  // Upper bound computed in 33 bits so a window ending at 2^32 does not wrap.
  logic [32:0] win_end;
  logic [32:0] mem_size_ext;

  assign mem_size_ext = {1'b0, MemSizeBytes};
  assign win_end      = {1'b0, MemBase} + mem_size_ext;

  assign addr_err_o = (addr_i[1:0] != 2'b00) |
                      (addr_i < MemBase) |
                      ({1'b0, addr_i} >= win_end);

  logic unused_in;
  assign unused_in = addr_err_o_unused_dummy;

endmodule

// File: rtl/cve2_instr_obi_responder.sv
// Instruction-side OBI responder with programmable grant wait states.
// Optional address range/alignment checking: CVE2_IMEM_RANGE_CHECK_EN.
module cve2_instr_obi_responder
  import cve2_pkg::*;
#(
  parameter logic [31:0] MemBase      = 32'h0000_0000,
  parameter int unsigned MemSizeBytes = 32768,
  parameter int unsigned WaitCycles   = 0,
  parameter int unsigned MemAw        = $clog2(MemSizeBytes / 4)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             instr_req_i,
  input  logic [31:0]      instr_addr_i,
  output logic             instr_gnt_o,
  output logic             instr_rvalid_o,
  output logic [31:0]      instr_rdata_o,
  output logic             instr_err_o,
  output logic             mem_req_o,
  output logic [MemAw-1:0] mem_addr_o,
  input  logic [31:0]      mem_rdata_i
);

  imem_resp_state_e      state_q, state_d;
  logic [ImemCntW-1:0]   cnt_q, cnt_d;
  logic                  gnt;
  logic                  granted;
  logic                  addr_err;
  logic                  resp_valid_q;
  logic                  resp_err_q;
  logic [31:0]           offset;

`ifdef CVE2_IMEM_RANGE_CHECK_EN
  cve2_imem_addr_check #(
    .MemBase      (MemBase),
    .MemSizeBytes (MemSizeBytes)
  ) u_addr_check (
    .addr_i                  (instr_addr_i),
    .addr_err_o_unused_dummy (1'b0),
    .addr_err_o              (addr_err)
  );
`else
  assign addr_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    case (state_q)
      IMEM_IDLE: begin
        if (instr_req_i) begin
          if (WaitCycles == 0) begin
            gnt = 1'b1;
          end else begin
            state_d = IMEM_WAIT;
            cnt_d   = imem_wait_init(WaitCycles);
          end
        end
      end
      IMEM_WAIT: begin
        // Initiator withdrew the request: abandon it silently.
        if (!instr_req_i) begin
          state_d = IMEM_IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          gnt     = 1'b1;
          state_d = IMEM_IDLE;
        end
      end
      default: begin
        state_d = IMEM_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IMEM_IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= granted;
      resp_err_q   <= granted & addr_err;
    end
  end

  // Outputs are held at zero while reset is asserted, which also drops a
  // response whose grant immediately preceded reset.
  assign instr_gnt_o    = gnt & rst_ni;
  assign granted        = instr_req_i & instr_gnt_o;
  assign mem_req_o      = granted & ~addr_err;
  assign offset         = instr_addr_i - MemBase;
  assign mem_addr_o     = rst_ni ? offset[MemAw+1:2] : '0;
  assign instr_rvalid_o = resp_valid_q & rst_ni;
  assign instr_err_o    = instr_rvalid_o & resp_err_q;
  assign instr_rdata_o  = (instr_rvalid_o & ~resp_err_q) ? mem_rdata_i : 32'h0000_0000;

  logic unused_offset;
  assign unused_offset = ^{offset[31:MemAw+2], offset[1:0]};

endmodule

// File: tb/tb_cve2_instr_obi_responder.sv
// Directed self-checking bench: three responders (0, 3 and 2 wait states).
module tb_cve2_instr_obi_responder;

  localparam int unsigned Aw = 13;

  logic clk;
  logic rst_n;

  logic          req_a, req_b, req_c;
  logic [31:0]   addr_a, addr_b, addr_c;
  logic          gnt_a, gnt_b, gnt_c;
  logic          rvalid_a, rvalid_b, rvalid_c;
  logic [31:0]   rdata_a, rdata_b, rdata_c;
  logic          err_a, err_b, err_c;
  logic          mreq_a, mreq_b, mreq_c;
  logic [Aw-1:0] maddr_a, maddr_b, maddr_c;
  logic [31:0]   mrdata_a, mrdata_b, mrdata_c;

  int n_checks;
  int n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM contents: word 4 holds a real instruction, the rest are tagged by index.
  function automatic logic [31:0] mword(input logic [Aw-1:0] idx);
    if (idx == 13'd4) return 32'h0000_0413;
    return {16'hC0DE, 3'b000, idx};
  endfunction

  always_ff @(posedge clk) if (mreq_a) mrdata_a <= mword(maddr_a);
  always_ff @(posedge clk) if (mreq_b) mrdata_b <= mword(maddr_b);
  always_ff @(posedge clk) if (mreq_c) mrdata_c <= mword(maddr_c);

  cve2_instr_obi_responder #(.MemBase(32'h0), .MemSizeBytes(32768), .WaitCycles(0)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req_a), .instr_addr_i(addr_a),
    .instr_gnt_o(gnt_a), .instr_rvalid_o(rvalid_a), .instr_rdata_o(rdata_a),
    .instr_err_o(err_a), .mem_req_o(mreq_a), .mem_addr_o(maddr_a), .mem_rdata_i(mrdata_a));

  cve2_instr_obi_responder #(.MemBase(32'h0), .MemSizeBytes(32768), .WaitCycles(3)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req_b), .instr_addr_i(addr_b),
    .instr_gnt_o(gnt_b), .instr_rvalid_o(rvalid_b), .instr_rdata_o(rdata_b),
    .instr_err_o(err_b), .mem_req_o(mreq_b), .mem_addr_o(maddr_b), .mem_rdata_i(mrdata_b));

  cve2_instr_obi_responder #(.MemBase(32'h0), .MemSizeBytes(32768), .WaitCycles(2)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req_c), .instr_addr_i(addr_c),
    .instr_gnt_o(gnt_c), .instr_rvalid_o(rvalid_c), .instr_rdata_o(rdata_c),
    .instr_err_o(err_c), .mem_req_o(mreq_c), .mem_addr_o(maddr_c), .mem_rdata_i(mrdata_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic check_a_idle(input string tag);
    check({tag, " gnt"},    {31'd0, gnt_a},    32'd0);
    check({tag, " rvalid"}, {31'd0, rvalid_a}, 32'd0);
    check({tag, " rdata"},  rdata_a,           32'd0);
    check({tag, " err"},    {31'd0, err_a},    32'd0);
    check({tag, " mreq"},   {31'd0, mreq_a},   32'd0);
    check({tag, " maddr"},  {19'd0, maddr_a},  32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    req_a = 1'b1; addr_a = 32'h10;
    req_b = 1'b0; addr_b = 32'h0;
    req_c = 1'b0; addr_c = 32'h0;

    // Reset: gnt/mem_req forced low even with a request pending.
    step(); step(); smp();
    check_a_idle("rst");
    check("rst rvalid_b", {31'd0, rvalid_b}, 32'd0);

    step(); rst_n = 1'b1; req_a = 1'b0; addr_a = 32'h0;
    smp();
    check_a_idle("post_rst");

    // Single fetch, zero wait states.
    step(); req_a = 1'b1; addr_a = 32'h10;
    smp();
    check("t1 gnt",   {31'd0, gnt_a},  32'd1);
    check("t1 mreq",  {31'd0, mreq_a}, 32'd1);
    check("t1 maddr", {19'd0, maddr_a}, 32'd4);
    step(); req_a = 1'b0; addr_a = 32'h0;
    smp();
    check("t1 rvalid", {31'd0, rvalid_a}, 32'd1);
    check("t1 rdata",  rdata_a,           32'h0000_0413);
    check("t1 err",    {31'd0, err_a},    32'd0);
    check("t1 gnt_off", {31'd0, gnt_a},   32'd0);

    // Three wait states: gnt in the 4th request cycle.
    step(); req_b = 1'b1; addr_b = 32'h0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) step();
      smp();
      check($sformatf("t2 gnt c%0d", c), {31'd0, gnt_b}, (c == 3) ? 32'd1 : 32'd0);
      check($sformatf("t2 rvalid c%0d", c), {31'd0, rvalid_b}, 32'd0);
    end
    step(); req_b = 1'b0;
    smp();
    check("t2 rvalid", {31'd0, rvalid_b}, 32'd1);
    check("t2 rdata",  rdata_b,           mword(13'd0));

    // Back-to-back fetches, one per cycle.
    for (int i = 0; i < 4; i++) begin
      step(); req_a = 1'b1; addr_a = 32'(4 * i);
      smp();
      check($sformatf("t3 gnt %0d", i),   {31'd0, gnt_a},   32'd1);
      check($sformatf("t3 maddr %0d", i), {19'd0, maddr_a}, 32'(i));
      check($sformatf("t3 rvalid %0d", i), {31'd0, rvalid_a}, (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) check($sformatf("t3 rdata %0d", i), rdata_a, mword(13'(i - 1)));
    end
    step(); req_a = 1'b0; addr_a = 32'h0;
    smp();
    check("t3 rvalid last", {31'd0, rvalid_a}, 32'd1);
    check("t3 rdata last",  rdata_a,           mword(13'd3));

    // Out-of-window and misaligned addresses.
    step(); req_a = 1'b1; addr_a = 32'h0000_8000;
    smp();
    check("t4a gnt", {31'd0, gnt_a}, 32'd1);
`ifdef CVE2_IMEM_RANGE_CHECK_EN
    check("t4a mreq", {31'd0, mreq_a}, 32'd0);
`else
    check("t4a mreq",  {31'd0, mreq_a},  32'd1);
    check("t4a maddr", {19'd0, maddr_a}, 32'd0);
`endif
    step(); addr_a = 32'h0000_0002;
    smp();
    check("t4b gnt", {31'd0, gnt_a}, 32'd1);
    check("t4a rvalid", {31'd0, rvalid_a}, 32'd1);
`ifdef CVE2_IMEM_RANGE_CHECK_EN
    check("t4b mreq",  {31'd0, mreq_a}, 32'd0);
    check("t4a err",   {31'd0, err_a},  32'd1);
    check("t4a rdata", rdata_a,         32'd0);
`else
    check("t4b mreq",  {31'd0, mreq_a},  32'd1);
    check("t4b maddr", {19'd0, maddr_a}, 32'd0);
    check("t4a err",   {31'd0, err_a},   32'd0);
    check("t4a rdata", rdata_a,          mword(13'd0));
`endif
    step(); req_a = 1'b0; addr_a = 32'h0;
    smp();
    check("t4b rvalid", {31'd0, rvalid_a}, 32'd1);
`ifdef CVE2_IMEM_RANGE_CHECK_EN
    check("t4b err",   {31'd0, err_a}, 32'd1);
    check("t4b rdata", rdata_a,        32'd0);
`else
    check("t4b err",   {31'd0, err_a}, 32'd0);
    check("t4b rdata", rdata_a,        mword(13'd0));
`endif

    // Two wait states, request withdrawn after one cycle.
    step(); req_c = 1'b1; addr_c = 32'h14;
    smp();
    check("t5 gnt0", {31'd0, gnt_c}, 32'd0);
    step(); req_c = 1'b0; addr_c = 32'h0;
    smp();
    check("t5 gnt1", {31'd0, gnt_c}, 32'd0);
    step(); smp();
    check("t5 rvalid drop", {31'd0, rvalid_c}, 32'd0);
    step(); req_c = 1'b1; addr_c = 32'h14;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) step();
      smp();
      check($sformatf("t5 regnt c%0d", c), {31'd0, gnt_c}, (c == 2) ? 32'd1 : 32'd0);
    end
    check("t5 maddr", {19'd0, maddr_c}, 32'd5);
    step(); req_c = 1'b0; addr_c = 32'h0;
    smp();
    check("t5 rvalid", {31'd0, rvalid_c}, 32'd1);
    check("t5 rdata",  rdata_c,           mword(13'd5));

    // Reset right after a grant drops the response.
    step(); req_a = 1'b1; addr_a = 32'h8;
    smp();
    check("t6 gnt", {31'd0, gnt_a}, 32'd1);
    step(); req_a = 1'b0; addr_a = 32'h0; rst_n = 1'b0;
    smp();
    check("t6 rvalid rst", {31'd0, rvalid_a}, 32'd0);
    check("t6 rdata rst",  rdata_a,           32'd0);
    step(); rst_n = 1'b1;
    smp();
    check_a_idle("t6 post");
    step(); smp();
    check_a_idle("t6 post2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
